// File: rtl/dtc_therm_decoder.sv
// Thermometer-code decoder for the decision-tree classifier output bus.
// Two-stage valid/ready pipeline with code check, error counter and peak tracker.
module dtc_therm_decoder #(
    parameter int W      = 12,
    parameter int LVL_W  = $clog2(W + 1),
    parameter int ERRC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_therm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  out_level,
    output logic              out_err,
    output logic [ERRC_W-1:0] err_count,
    output logic [LVL_W-1:0]  peak_level,
    input  logic              clear
);

    logic             adv;
    logic             xfer_out;
    logic             s1_valid;
    logic [W-1:0]     s1_therm;
    logic [LVL_W-1:0] s1_level;
    logic             s1_err;
    logic             err_load;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign xfer_out = out_valid && out_ready;

    // Popcount doubles as bubble correction for illegal codes.
    always_comb begin
        s1_level = '0;
        for (int i = 0; i < W; i++) begin
            s1_level = s1_level + LVL_W'(s1_therm[i]);
        end
    end

    // A legal code is 2^k-1: adding one clears every set bit.
    assign s1_err   = |(s1_therm & (s1_therm + W'(1)));
    assign err_load = adv && s1_valid && s1_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_therm <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_therm <= in_therm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_level <= '0;
            out_err   <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_level <= s1_level;
                out_err   <= s1_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (clear) begin
            err_count <= err_load ? ERRC_W'(1) : '0;
        end else if (err_load && !(&err_count)) begin
            err_count <= err_count + ERRC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_level <= '0;
        end else if (clear) begin
            peak_level <= xfer_out ? out_level : '0;
        end else if (xfer_out && (out_level > peak_level)) begin
            peak_level <= out_level;
        end
    end

endmodule

// File: tb/tb_dtc_therm_decoder.sv
// Directed-vector bench for dtc_therm_decoder.
// Main instance plus a narrow-counter instance for saturation.
module tb_dtc_therm_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_therm;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_level;
    logic        out_err;
    logic [15:0] err_count;
    logic [3:0]  peak_level;
    logic        clear;

    logic        d2_in_valid;
    logic        d2_in_ready;
    logic [11:0] d2_in_therm;
    logic        d2_out_valid;
    logic        d2_out_ready;
    logic [3:0]  d2_out_level;
    logic        d2_out_err;
    logic [1:0]  d2_err_count;
    logic [3:0]  d2_peak_level;
    logic        d2_clear;

    int cnt = 0;
    int bad = 0;
    int n_out = 0;
    logic [4:0] expq[$];

    always #5 clk = ~clk;

    dtc_therm_decoder u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_therm(in_therm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_level(out_level), .out_err(out_err),
        .err_count(err_count), .peak_level(peak_level),
        .clear(clear)
    );

    dtc_therm_decoder #(.ERRC_W(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .in_therm(d2_in_therm),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .out_level(d2_out_level), .out_err(d2_out_err),
        .err_count(d2_err_count), .peak_level(d2_peak_level),
        .clear(d2_clear)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        cnt++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_therm = 'x;
    endtask

    task automatic send(input logic [11:0] t, input logic [3:0] lvl,
                        input logic err);
        logic ok;
        int   n;
        in_valid = 1'b1;
        in_therm = t;
        expq.push_back({err, lvl});
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            step();
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard: every output transfer must match the next queued word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (expq.size() == 0) begin
                chk("spurious_out", {27'd0, out_err, out_level}, 32'h1f);
            end else begin
                logic [4:0] e;
                e = expq.pop_front();
                chk("out_level", {28'd0, out_level}, {28'd0, e[3:0]});
                chk("out_err", {31'd0, out_err}, {31'd0, e[4]});
            end
        end
    end

    initial begin
        int n0;
        rst = 1'b1;
        idle();
        out_ready = 1'b1;
        clear = 1'b0;
        d2_in_valid = 1'b0;
        d2_in_therm = 'x;
        d2_out_ready = 1'b1;
        d2_clear = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_level", {28'd0, out_level}, 32'd0);
        chk("rst_err", {31'd0, out_err}, 32'd0);
        chk("rst_errcnt", {16'd0, err_count}, 32'd0);
        chk("rst_peak", {28'd0, peak_level}, 32'd0);

        // Back-to-back legal codes 0..12
        n_out = 0;
        for (int k = 0; k <= 12; k++) begin
            logic [31:0] v;
            v = (32'd1 << k) - 32'd1;
            send(v[11:0], 4'(k), 1'b0);
            if (k == 0) chk("lat_0", {31'd0, out_valid}, 32'd0);
            if (k == 1) chk("lat_1", {31'd0, out_valid}, 32'd1);
        end
        idle();
        repeat (3) step();
        chk("stream_n", n_out, 32'd13);
        chk("stream_q", expq.size(), 32'd0);
        chk("stream_peak", {28'd0, peak_level}, 32'd12);
        chk("stream_errcnt", {16'd0, err_count}, 32'd0);

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_peak", {28'd0, peak_level}, 32'd0);

        // Illegal codes are bubble-corrected and counted
        send(12'b000000101111, 4'd5, 1'b1);
        idle();
        repeat (3) step();
        chk("err1_cnt", {16'd0, err_count}, 32'd1);
        send(12'b100000000000, 4'd1, 1'b1);
        idle();
        repeat (3) step();
        chk("err2_cnt", {16'd0, err_count}, 32'd2);
        chk("err_peak", {28'd0, peak_level}, 32'd5);

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr2_errcnt", {16'd0, err_count}, 32'd0);
        chk("clr2_peak", {28'd0, peak_level}, 32'd0);

        // Peak tracking, then clear coinciding with a transfer
        send(12'h07f, 4'd7, 1'b0);
        idle();
        repeat (3) step();
        chk("peak_7", {28'd0, peak_level}, 32'd7);
        send(12'hfff, 4'd12, 1'b0);
        idle();
        repeat (3) step();
        chk("peak_12", {28'd0, peak_level}, 32'd12);
        send(12'h007, 4'd3, 1'b0);
        idle();
        step();
        chk("peak_hold", {28'd0, peak_level}, 32'd12);
        chk("peak_pre_ov", {31'd0, out_valid}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("peak_clr_xfer", {28'd0, peak_level}, 32'd3);

        // Backpressure: three words, output stalled five cycles
        n0 = n_out;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_therm = 12'h003;
        expq.push_back({1'b0, 4'd2});
        step();
        in_therm = 12'h00f;
        expq.push_back({1'b0, 4'd4});
        step();
        in_therm = 12'h03f;
        expq.push_back({1'b0, 4'd6});
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_lvl", {28'd0, out_level}, 32'd2);
        end
        out_ready = 1'b1;
        step();
        idle();
        repeat (4) step();
        chk("bp_n", n_out - n0, 32'd3);
        chk("bp_q", expq.size(), 32'd0);

        // Reset with both stages holding stalled words
        n0 = n_out;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_therm = 12'h005;
        step();
        in_therm = 12'h009;
        step();
        chk("pre_rst_errcnt", {16'd0, err_count}, 32'd1);
        chk("pre_rst_peak", {28'd0, peak_level}, 32'd6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        out_ready = 1'b1;
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_errcnt", {16'd0, err_count}, 32'd0);
        chk("mrst_peak", {28'd0, peak_level}, 32'd0);
        repeat (4) step();
        chk("mrst_no_stale", n_out - n0, 32'd0);

        // Narrow counter saturates at 3
        d2_in_valid = 1'b1;
        d2_in_therm = 12'h002;
        step();
        d2_in_therm = 12'h004;
        step();
        d2_in_therm = 12'h00a;
        step();
        d2_in_therm = 12'h100;
        step();
        d2_in_therm = 12'h801;
        step();
        d2_in_valid = 1'b0;
        d2_in_therm = 'x;
        repeat (3) step();
        chk("sat_cnt", {30'd0, d2_err_count}, 32'd3);
        chk("sat_last_err", {31'd0, d2_out_err}, 32'd1);
        chk("sat_last_lvl", {28'd0, d2_out_level}, 32'd2);
        d2_in_valid = 1'b1;
        d2_in_therm = 12'h002;
        step();
        d2_in_valid = 1'b0;
        d2_in_therm = 'x;
        d2_clear = 1'b1;
        step();
        d2_clear = 1'b0;
        chk("clr_with_err", {30'd0, d2_err_count}, 32'd1);
        d2_clear = 1'b1;
        step();
        d2_clear = 1'b0;
        chk("clr_alone", {30'd0, d2_err_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, bad);
        $finish;
    end

endmodule
